// File: rtl/rot_mtrx_pkg.sv
// Shared constants and types for the rotation-matrix generator.
// Angles are Q1.2.13 radians; CORDIC x/y are Q1.1.14.
package rot_mtrx_pkg;

  localparam logic signed [15:0] CORDIC_K    = 16'sh26DD;  // 0.6072529 * 2^14
  localparam logic signed [15:0] PI_Q13      = 16'sh6488;
  localparam logic signed [15:0] HALF_PI_Q13 = 16'sh3244;

  localparam logic [1:0] AXIS_X  = 2'd0;
  localparam logic [1:0] AXIS_Y  = 2'd1;
  localparam logic [1:0] AXIS_Z  = 2'd2;
  localparam logic [1:0] AXIS_ID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } rot_state_t;

  // atan(2^-i) in Q1.2.13, rounded to nearest
  function automatic logic signed [15:0] atan_q13(input logic [3:0] idx);
    logic signed [15:0] v;
    case (idx)
      4'd0:    v = 16'sd6434;
      4'd1:    v = 16'sd3798;
      4'd2:    v = 16'sd2007;
      4'd3:    v = 16'sd1019;
      4'd4:    v = 16'sd511;
      4'd5:    v = 16'sd256;
      4'd6:    v = 16'sd128;
      4'd7:    v = 16'sd64;
      4'd8:    v = 16'sd32;
      4'd9:    v = 16'sd16;
      4'd10:   v = 16'sd8;
      4'd11:   v = 16'sd4;
      4'd12:   v = 16'sd2;
      4'd13:   v = 16'sd1;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rotate_axis_matrix_cordic.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock.
// x starts at K so the final x/y are cos/sin of the start angle without a gain fix-up.
// o_done pulses for one cycle, the cycle after the last micro-rotation.
module cordic_rot_iter
  import rot_mtrx_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ITER    = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic signed [ANGLE_W-1:0] i_z0,
  output logic signed [15:0]        o_x,
  output logic signed [15:0]        o_y,
  output logic                      o_done
);

  logic signed [15:0]        r_x;
  logic signed [15:0]        r_y;
  logic signed [ANGLE_W-1:0] r_z;
  logic [3:0]                r_cnt;
  logic                      r_busy;
  logic                      r_done;

  logic signed [15:0]        w_xs;
  logic signed [15:0]        w_ys;
  logic signed [ANGLE_W-1:0] w_atan;
  logic                      w_neg;

  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_atan = ANGLE_W'(atan_q13(r_cnt));
  assign w_neg  = r_z[ANGLE_W-1];

  // Load on start, then rotate toward z=0 until the last iteration index
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_x    <= CORDIC_K;
        r_y    <= '0;
        r_z    <= i_z0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (w_neg) begin
          r_x <= r_x + w_ys;
          r_y <= r_y - w_xs;
          r_z <= r_z + w_atan;
        end else begin
          r_x <= r_x - w_ys;
          r_y <= r_y + w_xs;
          r_z <= r_z - w_atan;
        end
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'(ITER - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_done = r_done;

endmodule

// File: rtl/rotate_axis_matrix.sv
// 4x4 homogeneous rotation-matrix generator about X/Y/Z (axis 3 = identity).
// Angles beyond +/-pi/2 are folded by pi and the resulting cos/sin negated.
// Optional macro ROT_MTRX_ROUND_EN: round-half-up and saturate the Q14 -> element
// conversion; otherwise a plain flooring shift.
module rotate_axis_matrix
  import rot_mtrx_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ELEM_W  = 21,
  parameter int ELEM_FR = 10,
  parameter int ITER    = 14
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ANGLE_W-1:0] angle,
  input  logic [1:0]                axis,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [16*ELEM_W-1:0]      rot_mtrx
);

  localparam int SHIFT = 14 - ELEM_FR;
  localparam logic signed [ELEM_W-1:0] ONE = ELEM_W'(1) << ELEM_FR;

  rot_state_t           r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [16*ELEM_W-1:0] r_rot;
  logic [1:0]           r_axis;
  logic                 r_flip;

  logic                      w_accept;
  logic signed [ANGLE_W-1:0] w_z0;
  logic                      w_flip;
  logic signed [15:0]        w_x;
  logic signed [15:0]        w_y;
  logic                      w_done;
  logic signed [16:0]        w_c17;
  logic signed [16:0]        w_s17;
  logic signed [ELEM_W-1:0]  w_c;
  logic signed [ELEM_W-1:0]  w_s;
  logic signed [ELEM_W-1:0]  w_ns;
  logic signed [ELEM_W-1:0]  w_m [16];
  logic [16*ELEM_W-1:0]      w_mtrx;

  function automatic logic signed [ELEM_W-1:0] q14_to_elem(input logic signed [16:0] v);
    logic signed [31:0] t;
`ifdef ROT_MTRX_ROUND_EN
    logic signed [31:0] lim_hi;
    logic signed [31:0] lim_lo;
    lim_hi = (32'sd1 <<< (ELEM_W - 1)) - 32'sd1;
    lim_lo = -(32'sd1 <<< (ELEM_W - 1));
    t = 32'(v) + (32'sd1 <<< (13 - ELEM_FR));
    t = t >>> SHIFT;
    if (t > lim_hi)      t = lim_hi;
    else if (t < lim_lo) t = lim_lo;
`else
    t = 32'(v) >>> SHIFT;
`endif
    return t[ELEM_W-1:0];
  endfunction

  assign w_accept = in_valid & r_in_ready;

  // Fold the angle into the CORDIC convergence range
  always_comb begin
    w_z0   = angle;
    w_flip = 1'b0;
    if (angle > ANGLE_W'(HALF_PI_Q13)) begin
      w_z0   = angle - ANGLE_W'(PI_Q13);
      w_flip = 1'b1;
    end else if (angle < -ANGLE_W'(HALF_PI_Q13)) begin
      w_z0   = angle + ANGLE_W'(PI_Q13);
      w_flip = 1'b1;
    end
  end

  cordic_rot_iter #(
    .ANGLE_W (ANGLE_W),
    .ITER    (ITER)
  ) u_cordic (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_start (w_accept),
    .i_z0    (w_z0),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_done  (w_done)
  );

  // Undo the fold in Q14 (17 bits so negating -1.0 cannot wrap), then convert
  always_comb begin
    w_c17 = r_flip ? -17'(w_x) : 17'(w_x);
    w_s17 = r_flip ? -17'(w_y) : 17'(w_y);
    w_c   = q14_to_elem(w_c17);
    w_s   = q14_to_elem(w_s17);
    w_ns  = -w_s;
  end

  // Place cos/sin into the row-major matrix for the latched axis
  always_comb begin
    for (int k = 0; k < 16; k++) w_m[k] = '0;
    w_m[15] = ONE;
    case (r_axis)
      AXIS_X: begin
        w_m[0]  = ONE;
        w_m[5]  = w_c;
        w_m[6]  = w_ns;
        w_m[9]  = w_s;
        w_m[10] = w_c;
      end
      AXIS_Y: begin
        w_m[0]  = w_c;
        w_m[2]  = w_s;
        w_m[5]  = ONE;
        w_m[8]  = w_ns;
        w_m[10] = w_c;
      end
      AXIS_Z: begin
        w_m[0]  = w_c;
        w_m[1]  = w_ns;
        w_m[4]  = w_s;
        w_m[5]  = w_c;
        w_m[10] = ONE;
      end
      default: begin
        w_m[0]  = ONE;
        w_m[5]  = ONE;
        w_m[10] = ONE;
      end
    endcase
    w_mtrx = '0;
    for (int k = 0; k < 16; k++) w_mtrx[(15-k)*ELEM_W +: ELEM_W] = w_m[k];
  end

  // Handshake FSM with registered ready/valid and result matrix
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_axis      <= AXIS_ID;
      r_flip      <= 1'b0;
      r_rot       <= '0;
      r_rot[15*ELEM_W +: ELEM_W] <= ONE;
      r_rot[10*ELEM_W +: ELEM_W] <= ONE;
      r_rot[5*ELEM_W  +: ELEM_W] <= ONE;
      r_rot[0         +: ELEM_W] <= ONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_axis     <= axis;
            r_flip     <= w_flip;
            r_in_ready <= 1'b0;
            r_state    <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (w_done) begin
            r_rot       <= w_mtrx;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign rot_mtrx  = r_rot;

endmodule

// File: tb/tb_rotate_axis_matrix.sv
// Self-checking bench for rotate_axis_matrix: expected matrices come from real
// cos/sin placed into the textbook per-axis rotation layouts.
module tb_rotate_axis_matrix;

  localparam int ELEM_W  = 21;
  localparam int ELEM_FR = 10;
  localparam int ITER    = 14;
  localparam int ONE     = 1 << ELEM_FR;
  localparam int TOL     = 2;

  logic                 CLK = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic [15:0]          angle = '0;
  logic [1:0]           axis = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [16*ELEM_W-1:0] rot_mtrx;

  int errors = 0;
  int checks = 0;
  int exp_m [16];
  int tol_m [16];
  int got_m [16];

  rotate_axis_matrix dut (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .axis      (axis),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rot_mtrx  (rot_mtrx)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Reference cos/sin of the requested angle, in element LSBs
  task automatic model_cs(input logic [15:0] an, output int c, output int s);
    real th;
    th = real'($signed(an)) / 8192.0;
    c  = rnd($cos(th) * real'(ONE));
    s  = rnd($sin(th) * real'(ONE));
  endtask

  // Standard rotation matrices R_x, R_y, R_z (index = 4*(row-1)+(col-1))
  task automatic build_expected(input int ax, input int c, input int s);
    for (int k = 0; k < 16; k++) begin
      exp_m[k] = 0;
      tol_m[k] = 0;
    end
    exp_m[15] = ONE;
    case (ax)
      0: begin
        exp_m[0] = ONE;
        exp_m[5] = c;  exp_m[6] = -s;  exp_m[9] = s;  exp_m[10] = c;
        tol_m[5] = TOL; tol_m[6] = TOL; tol_m[9] = TOL; tol_m[10] = TOL;
      end
      1: begin
        exp_m[5] = ONE;
        exp_m[0] = c;  exp_m[2] = s;  exp_m[8] = -s;  exp_m[10] = c;
        tol_m[0] = TOL; tol_m[2] = TOL; tol_m[8] = TOL; tol_m[10] = TOL;
      end
      2: begin
        exp_m[10] = ONE;
        exp_m[0] = c;  exp_m[1] = -s;  exp_m[4] = s;  exp_m[5] = c;
        tol_m[0] = TOL; tol_m[1] = TOL; tol_m[4] = TOL; tol_m[5] = TOL;
      end
      default: begin
        exp_m[0] = ONE; exp_m[5] = ONE; exp_m[10] = ONE;
      end
    endcase
  endtask

  task automatic capture();
    for (int k = 0; k < 16; k++)
      got_m[k] = int'($signed(rot_mtrx[(15-k)*ELEM_W +: ELEM_W]));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_req(input logic [1:0] ax, input logic [15:0] an, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    axis     = ax;
    angle    = an;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    ok = in_ready;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Edges since the accept edge until out_valid is seen (bounded)
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    build_expected(3, 0, 0);
    capture();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL reset_mtrx m%0d%0d got=%0d exp=%0d", k/4+1, k%4+1, got_m[k], exp_m[k]);
      end
    end
    rst = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_directed();
    logic [1:0]  ax_t [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic [15:0] an_t [4] = '{16'h0000, 16'h3244, 16'h6488, 16'hEF3E};
    int          c_t  [4] = '{'h400, 0, -'h400, 'h377};
    int          s_t  [4] = '{0, 'h400, 0, -'h200};
    bit ok;
    int lat;
    for (int t = 0; t < 4; t++) begin
      send_req(ax_t[t], an_t[t], ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++; $display("FAIL directed%0d_accept got=%b exp=1", t, ok);
      end
      wait_out(lat);
      checks++;
      if (lat !== ITER + 1) begin
        errors++; $display("FAIL directed%0d_latency got=%0d exp=%0d", t, lat, ITER + 1);
      end
      build_expected(int'(ax_t[t]), c_t[t], s_t[t]);
      capture();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (iabs(got_m[k] - exp_m[k]) > tol_m[k]) begin
          errors++;
          $display("FAIL directed%0d m%0d%0d got=%0d exp=%0d tol=%0d", t, k/4+1, k%4+1, got_m[k], exp_m[k], tol_m[k]);
        end
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL directed%0d_after_hs got out_valid=%b in_ready=%b exp 0/1", t, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [16*ELEM_W-1:0] held;
    send_req(2'd2, 16'h1000, ok);
    wait_out(lat);
    checks++;
    if (lat !== ITER + 1) begin
      errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, ITER + 1);
    end
    held     = rot_mtrx;
    in_valid = 1'b1;
    axis     = 2'd0;
    angle    = 16'h0800;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rot_mtrx !== held) begin
        errors++;
        $display("FAIL bp_hold cycle%0d got out_valid=%b in_ready=%b stable=%b exp 1/0/1", n, out_valid, in_ready, rot_mtrx === held);
      end
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || rot_mtrx !== held) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b retained=%b exp 1/0/1", in_ready, out_valid, rot_mtrx === held);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept got in_ready=%b exp=0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat !== ITER + 1) begin
      errors++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, ITER + 1);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat, c, s;
    logic [15:0] an2;
    send_req(2'd1, 16'hE000, ok);
    wait_out(lat);
    an2       = 16'h2400;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    axis      = 2'd0;
    angle     = an2;
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept got in_ready=%b exp=0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat !== ITER + 1) begin
      errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, ITER + 1);
    end
    model_cs(an2, c, s);
    build_expected(0, c, s);
    capture();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (iabs(got_m[k] - exp_m[k]) > tol_m[k]) begin
        errors++; $display("FAIL b2b m%0d%0d got=%0d exp=%0d", k/4+1, k%4+1, got_m[k], exp_m[k]);
      end
    end
    consume();
  endtask

  task automatic test_random();
    bit ok;
    int lat, c, s, a, ax;
    logic [15:0] an;
    for (int t = 0; t < 24; t++) begin
      a  = int'($urandom_range(0, 2 * 'h6488)) - 'h6488;
      an = 16'(a);
      ax = int'($urandom_range(0, 3));
      send_req(2'(ax), an, ok);
      wait_out(lat);
      checks++;
      if (lat !== ITER + 1) begin
        errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, ITER + 1);
      end
      model_cs(an, c, s);
      build_expected(ax, c, s);
      capture();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (iabs(got_m[k] - exp_m[k]) > tol_m[k]) begin
          errors++;
          $display("FAIL rand%0d ax=%0d ang=%h m%0d%0d got=%0d exp=%0d", t, ax, an, k/4+1, k%4+1, got_m[k], exp_m[k]);
        end
      end
      consume();
    end
  endtask

  task automatic test_identity();
    bit ok;
    int lat;
    send_req(2'd2, 16'h1800, ok);
    wait_out(lat);
    consume();
    send_req(2'd3, 16'(int'($urandom_range(0, 'h6488))), ok);
    wait_out(lat);
    checks++;
    if (lat !== ITER + 1) begin
      errors++; $display("FAIL ident_latency got=%0d exp=%0d", lat, ITER + 1);
    end
    build_expected(3, 0, 0);
    capture();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL ident m%0d%0d got=%0d exp=%0d", k/4+1, k%4+1, got_m[k], exp_m[k]);
      end
    end
    consume();
  endtask

  task automatic test_reset_mid_iter();
    bit ok;
    bit seen;
    send_req(2'd1, 16'h1234, ok);
    repeat (5) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    build_expected(3, 0, 0);
    capture();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL midrst_mtrx m%0d%0d got=%0d exp=%0d", k/4+1, k%4+1, got_m[k], exp_m[k]);
      end
    end
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midrst_no_output got out_valid_seen=%b exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_identity();
    test_reset_mid_iter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
